// File: rtl/vga_timing.sv
// Raster timing generator: registered pixel coordinates, sync pulses, display
// enable and line/frame ticks. All outputs are derived from the same next-state coordinates.
module vga_timing #(
  parameter int unsigned hVisible = 800,
  parameter int unsigned hFront   = 56,
  parameter int unsigned hSync    = 120,
  parameter int unsigned hBack    = 64,
  parameter int unsigned vVisible = 600,
  parameter int unsigned vFront   = 37,
  parameter int unsigned vSync    = 6,
  parameter int unsigned vBack    = 23,
  parameter bit          hSyncPol = 1'b1,
  parameter bit          vSyncPol = 1'b1
) (
  input  logic        PixelClock,
  input  logic        ResetN,
  output logic [11:0] xPos,
  output logic [11:0] yPos,
  output logic        hSyncOut,
  output logic        vSyncOut,
  output logic        displayEnable,
  output logic        lineTick,
  output logic        frameTick
);

  localparam int unsigned HTotal = hVisible + hFront + hSync + hBack;
  localparam int unsigned VTotal = vVisible + vFront + vSync + vBack;

  localparam logic [11:0] XMax     = 12'(HTotal - 1);
  localparam logic [11:0] YMax     = 12'(VTotal - 1);
  localparam logic [11:0] HVis     = 12'(hVisible);
  localparam logic [11:0] VVis     = 12'(vVisible);
  localparam logic [11:0] VLast    = 12'(vVisible - 1);
  localparam logic [11:0] HsStart  = 12'(hVisible + hFront);
  localparam logic [11:0] HsEnd    = 12'(hVisible + hFront + hSync);
  localparam logic [11:0] VsStart  = 12'(vVisible + vFront);
  localparam logic [11:0] VsEnd    = 12'(vVisible + vFront + vSync);

  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic        lt_q, lt_d;
  logic        ft_q, ft_d;

  // Qualifiers are computed from the next coordinates so they register in
  // lockstep with xPos/yPos and never skew against them.
  always_comb begin
    x_d = x_q + 12'd1;
    y_d = y_q;
    if (x_q >= XMax) begin
      x_d = 12'd0;
      y_d = (y_q >= YMax) ? 12'd0 : y_q + 12'd1;
    end
    de_d = (x_d < HVis) && (y_d < VVis);
    hs_d = ((x_d >= HsStart) && (x_d < HsEnd)) ? hSyncPol : ~hSyncPol;
    vs_d = ((y_d >= VsStart) && (y_d < VsEnd)) ? vSyncPol : ~vSyncPol;
    lt_d = (x_d == HVis);
    ft_d = (x_d == HVis) && (y_d == VLast);
  end

  always_ff @(posedge PixelClock or negedge ResetN) begin
    if (!ResetN) begin
      x_q  <= 12'd0;
      y_q  <= 12'd0;
      hs_q <= ~hSyncPol;
      vs_q <= ~vSyncPol;
      de_q <= 1'b0;
      lt_q <= 1'b0;
      ft_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      lt_q <= lt_d;
      ft_q <= ft_d;
    end
  end

  assign xPos          = x_q;
  assign yPos          = y_q;
  assign hSyncOut      = hs_q;
  assign vSyncOut      = vs_q;
  assign displayEnable = de_q;
  assign lineTick      = lt_q;
  assign frameTick     = ft_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default timing, inverted sync polarity and a
// small 15x7 raster checked cycle by cycle against hand-derived expectations.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] x0, y0, x1, y1, x2, y2;
  logic hs0, vs0, de0, lt0, ft0;
  logic hs1, vs1, de1, lt1, ft1;
  logic hs2, vs2, de2, lt2, ft2;

  vga_timing u_def (
    .PixelClock(clk), .ResetN(rst_n), .xPos(x0), .yPos(y0), .hSyncOut(hs0),
    .vSyncOut(vs0), .displayEnable(de0), .lineTick(lt0), .frameTick(ft0)
  );

  vga_timing #(.hSyncPol(1'b0), .vSyncPol(1'b0)) u_neg (
    .PixelClock(clk), .ResetN(rst_n), .xPos(x1), .yPos(y1), .hSyncOut(hs1),
    .vSyncOut(vs1), .displayEnable(de1), .lineTick(lt1), .frameTick(ft1)
  );

  vga_timing #(
    .hVisible(8), .hFront(2), .hSync(3), .hBack(2),
    .vVisible(4), .vFront(1), .vSync(1), .vBack(1)
  ) u_small (
    .PixelClock(clk), .ResetN(rst_n), .xPos(x2), .yPos(y2), .hSyncOut(hs2),
    .vSyncOut(vs2), .displayEnable(de2), .lineTick(lt2), .frameTick(ft2)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if ({x0, y0, de0, hs0, vs0, lt0, ft0} !== {12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_def: got x=%0d y=%0d de=%b hs=%b vs=%b lt=%b ft=%b want 0 0 0 0 0 0 0",
               x0, y0, de0, hs0, vs0, lt0, ft0);
    end
    n_tests++;
    if ({hs1, vs1, de1} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_neg: got hs=%b vs=%b de=%b want 1 1 0", hs1, vs1, de1);
    end
    n_tests++;
    if ({x2, y2, lt2, ft2} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_small: got x=%0d y=%0d lt=%b ft=%b want 0 0 0 0", x2, y2, lt2, ft2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({x0, y0, de0, lt0, ft0} !== {12'd1, 12'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL first_edge: got x=%0d y=%0d de=%b lt=%b ft=%b want 1 0 1 0 0",
               x0, y0, de0, lt0, ft0);
    end
  endtask

  // Runs one full line (1040 cycles) from (1,0) on both default-timing instances.
  task automatic test_line();
    int ex = 1;
    int ey = 0;
    int hs_cnt = 0;
    int de_cnt = 0;
    int lt_cnt = 0;
    logic e_de, e_hs, e_vs, e_lt, e_ft;
    for (int c = 0; c < 1040; c++) begin
      @(posedge clk);
      #1;
      if (ex == 1039) begin
        ex = 0;
        ey = (ey == 665) ? 0 : ey + 1;
      end else begin
        ex = ex + 1;
      end
      e_de = (ex < 800) && (ey < 600);
      e_hs = (ex >= 856) && (ex < 976);
      e_vs = (ey >= 637) && (ey < 643);
      e_lt = (ex == 800);
      e_ft = (ex == 800) && (ey == 599);
      if (hs0) hs_cnt++;
      if (de0) de_cnt++;
      if (lt0) lt_cnt++;
      n_tests++;
      if ({x0, y0, de0, hs0, vs0, lt0, ft0} !== {12'(ex), 12'(ey), e_de, e_hs, e_vs, e_lt, e_ft})
      begin
        n_fail++;
        $display("FAIL line_def: got x=%0d y=%0d de=%b hs=%b vs=%b lt=%b ft=%b want %0d %0d %b %b %b %b %b",
                 x0, y0, de0, hs0, vs0, lt0, ft0, ex, ey, e_de, e_hs, e_vs, e_lt, e_ft);
      end
      n_tests++;
      if ({hs1, vs1} !== {~e_hs, ~e_vs}) begin
        n_fail++;
        $display("FAIL line_neg: at x=%0d got hs=%b vs=%b want %b %b",
                 ex, hs1, vs1, ~e_hs, ~e_vs);
      end
    end
    n_tests++;
    if (hs_cnt != 120) begin
      n_fail++;
      $display("FAIL hsync_width: got %0d want 120", hs_cnt);
    end
    n_tests++;
    if (de_cnt != 800) begin
      n_fail++;
      $display("FAIL de_count: got %0d want 800", de_cnt);
    end
    n_tests++;
    if (lt_cnt != 1) begin
      n_fail++;
      $display("FAIL linetick_count: got %0d want 1", lt_cnt);
    end
    n_tests++;
    if ({x0, y0} !== {12'd1, 12'd1}) begin
      n_fail++;
      $display("FAIL next_line: got x=%0d y=%0d want 1 1", x0, y0);
    end
  endtask

  // Asserts reset between edges mid-line and expects outputs to clear at once.
  task automatic test_reset_midline();
    repeat (399) @(posedge clk);
    #1;
    n_tests++;
    if (x0 !== 12'd400) begin
      n_fail++;
      $display("FAIL pre_reset_pos: got x=%0d want 400", x0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({x0, y0, de0, hs0, vs0, lt0, ft0, hs1, vs1} !== {24'd0, 5'b00000, 2'b11}) begin
      n_fail++;
      $display("FAIL async_reset: got x=%0d y=%0d de=%b hs=%b vs=%b hsn=%b vsn=%b want 0 0 0 0 0 1 1",
               x0, y0, de0, hs0, vs0, hs1, vs1);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({x0, y0, de0} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_held: got x=%0d y=%0d de=%b want 0 0 0", x0, y0, de0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({x0, y0, de0, lt0, ft0, x2, y2} !== {12'd1, 12'd0, 3'b100, 12'd1, 12'd0}) begin
      n_fail++;
      $display("FAIL restart: got x=%0d y=%0d de=%b lt=%b ft=%b sx=%0d sy=%0d want 1 0 1 0 0 1 0",
               x0, y0, de0, lt0, ft0, x2, y2);
    end
  endtask

  // Three frames of the 15x7 raster, starting from (1,0).
  task automatic test_small();
    int sx = 1;
    int sy = 0;
    int lt_cnt = 0;
    int ft_cnt = 0;
    int ft_last = -1;
    int ft_gap = 0;
    logic e_de, e_hs, e_vs, e_lt, e_ft;
    for (int c = 0; c < 315; c++) begin
      @(posedge clk);
      #1;
      if (sx == 14) begin
        sx = 0;
        sy = (sy == 6) ? 0 : sy + 1;
      end else begin
        sx = sx + 1;
      end
      e_de = (sx < 8) && (sy < 4);
      e_hs = (sx >= 10) && (sx < 13);
      e_vs = (sy == 5);
      e_lt = (sx == 8);
      e_ft = (sx == 8) && (sy == 3);
      if (lt2) lt_cnt++;
      if (ft2) begin
        ft_cnt++;
        if (ft_last >= 0) ft_gap = c - ft_last;
        ft_last = c;
      end
      n_tests++;
      if ({x2, y2, de2, hs2, vs2, lt2, ft2} !== {12'(sx), 12'(sy), e_de, e_hs, e_vs, e_lt, e_ft})
      begin
        n_fail++;
        $display("FAIL small_cycle: got x=%0d y=%0d de=%b hs=%b vs=%b lt=%b ft=%b want %0d %0d %b %b %b %b %b",
                 x2, y2, de2, hs2, vs2, lt2, ft2, sx, sy, e_de, e_hs, e_vs, e_lt, e_ft);
      end
      n_tests++;
      if (x2 > 12'd14 || y2 > 12'd6) begin
        n_fail++;
        $display("FAIL small_range: got x=%0d y=%0d want x<=14 y<=6", x2, y2);
      end
    end
    n_tests++;
    if (lt_cnt != 21) begin
      n_fail++;
      $display("FAIL small_lineticks: got %0d want 21", lt_cnt);
    end
    n_tests++;
    if (ft_cnt != 3) begin
      n_fail++;
      $display("FAIL small_frameticks: got %0d want 3", ft_cnt);
    end
    n_tests++;
    if (ft_gap != 105) begin
      n_fail++;
      $display("FAIL small_frame_period: got %0d want 105", ft_gap);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_line();
    test_reset_midline();
    test_small();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
Raster timing generator that produces the xPos/yPos pixel coordinates consumed by the on-screen object modules (ball, paddles) of the Pong game. It also produces the monitor hSync/vSync signals and a display-enable qualifier for the colour mux in the top module. It provides a one-cycle frame tick so game objects can update once per frame during vertical blanking. Defaults give 800x600 @ 72 Hz from a 50 MHz PixelClock.

Parameters:
hVisible, 800, active pixels per line
hFront, 56, horizontal front porch (clocks)
hSync, 120, horizontal sync width (clocks)
hBack, 64, horizontal back porch (clocks)
vVisible, 600, active lines per frame
vFront, 37, vertical front porch (lines)
vSync, 6, vertical sync width (lines)
vBack, 23, vertical back porch (lines)
hSyncPol, 1, hSync active level (1 = active-high)
vSyncPol, 1, vSync active level

Ports:
PixelClock  input  1  pixel clock; all state changes on its rising edge
ResetN  input  1  asynchronous, active-low reset
xPos  output  12  horizontal counter, 0..HTOTAL-1
yPos  output  12  vertical counter, 0..VTOTAL-1
hSyncOut  output  1  horizontal sync at hSyncPol level while asserted
vSyncOut  output  1  vertical sync at vSyncPol level while asserted
displayEnable  output  1  1 when xPos<hVisible and yPos<vVisible
lineTick  output  1  one-cycle pulse at the start of horizontal blanking
frameTick  output  1  one-cycle pulse at the start of vertical blanking

Behaviour:
- Reset is asynchronous and active-low; one clock domain only (PixelClock). No other clock or reset.
- HTOTAL = hVisible+hFront+hSync+hBack (1040 default). VTOTAL = vVisible+vFront+vSync+vBack (666 default). Both must be <= 4096. Each field must be >= 1.
- All outputs are registered. Within any cycle, every output is a function of that same cycle's (xPos, yPos); there is no skew between the coordinates and the qualifiers.
- Reset asserted, immediately and for as long as it is held: xPos=0, yPos=0, displayEnable=0, lineTick=0, frameTick=0, hSyncOut=!hSyncPol, vSyncOut=!vSyncPol.
- First rising edge after ResetN rises: xPos=1, yPos=0, displayEnable=1. Pixel (0,0) of frame 0 is not shown; this is accepted.
- Counting, each edge:
  - If xPos < HTOTAL-1, then xPos+1.
  - Otherwise xPos=0, and yPos advances: yPos+1, or 0 if yPos = VTOTAL-1.
- hSyncOut is at hSyncPol level iff hVisible+hFront <= xPos < hVisible+hFront+hSync (default 856..975). Otherwise it is at the inverse level.
- vSyncOut is at vSyncPol level iff vVisible+vFront <= yPos < vVisible+vFront+vSync (default 637..642). It is line-based and changes only together with xPos=0.
- displayEnable = (xPos<hVisible) & (yPos<vVisible). It is asserted on all lines, including blank ones, only under that condition.
- lineTick = 1 iff xPos==hVisible. It fires on every line, visible and blank: once per HTOTAL cycles.
- frameTick = 1 iff xPos==hVisible and yPos==vVisible-1, i.e. the first blanking cycle after the last visible pixel. It fires exactly once per HTOTAL*VTOTAL cycles.
- Wrap (HTOTAL-1, VTOTAL-1) -> (0,0) produces no tick. displayEnable rises on the (0,0) cycle.
- Reset mid-frame: outputs go to reset values asynchronously, with no partial tick. Counting restarts as above.
- Counters never exceed HTOTAL-1 / VTOTAL-1. No state is reachable outside those ranges.

Test Plan:
- Hold ResetN=0 for 5 clocks, then drop it mid-frame at (400,300) -> outputs at reset values at once. First edge after release gives xPos=1, yPos=0, displayEnable=1, no tick.
- Run one line with defaults -> hSyncOut high for exactly 120 cycles at xPos 856..975. displayEnable high for xPos 0..799. lineTick high only at xPos=800. Next line starts with xPos=0, yPos+1 after 1040 cycles.
- Run a full frame -> vSyncOut high for 6 lines (yPos 637..642, 6240 cycles). frameTick high once, at (800,599). The next frameTick comes exactly 692640 cycles later. yPos wraps 665 -> 0.
- Small config (H 8/2/3/2, V 4/1/1/1, HTOTAL=15, VTOTAL=7) -> compare every cycle of 3 frames against a reference model. lineTick count = 21, frameTick count = 3, no counter value out of range.
- hSyncPol=0, vSyncPol=0 -> sync outputs idle high and pulse low in the same windows as the default test. During reset both sit at 1.
